uart_mmio_ctrl: RTL and testbench



---
 rtl/uart_mmio_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped 8N1 UART for the RV32I data bus; read data is combinational.
// Define UART_PARITY_EN to add an even-parity bit (11-bit frames) and a sticky parity_err.
module uart_mmio_ctrl #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              uart_tx,
  input  logic              uart_rx
);

  // Same values as the mem_pkg UART constants used by the core's address decode.
  localparam logic [31:0] UART_TX_ADDR      = 32'h1001_0300;
  localparam logic [31:0] UART_RX_ADDR      = 32'h1001_0304;
  localparam logic [31:0] UART_BUSY_ADDR    = 32'h1001_0308;
  localparam logic [31:0] UART_RX_DONE_ADDR = 32'h1001_030c;

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

`ifdef UART_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  logic hit_tx, hit_rx, hit_busy, hit_done;
  logic unused_wdata;

  assign hit_tx   = (addr == UART_TX_ADDR);
  assign hit_rx   = (addr == UART_RX_ADDR);
  assign hit_busy = (addr == UART_BUSY_ADDR);
  assign hit_done = (addr == UART_RX_DONE_ADDR);
  assign sel      = hit_tx | hit_rx | hit_busy | hit_done;
  assign unused_wdata = ^wdata[DATA_W-1:8];

  // ---------------- TX path ----------------
  state_e           tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             uart_tx_q, uart_tx_d;
  logic             busy_q, busy_d;
  logic             tx_bit_end;
  logic             tx_start;
`ifdef UART_PARITY_EN
  logic             tx_par_q, tx_par_d;
`endif

  assign tx_bit_end = (tx_cnt_q == CNT_LAST);
  assign tx_start   = we & hit_tx & ~busy_q;
  assign uart_tx    = uart_tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    uart_tx_d  = uart_tx_q;
    busy_d     = busy_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      ST_IDLE: begin
        if (tx_start) begin
          tx_shift_d = wdata[7:0];
`ifdef UART_PARITY_EN
          tx_par_d   = even_parity(wdata[7:0]);
`endif
          tx_cnt_d   = CNT_ZERO;
          uart_tx_d  = 1'b0;
          busy_d     = 1'b1;
          tx_state_d = ST_START;
        end else begin
          uart_tx_d  = 1'b1;
          busy_d     = 1'b0;
        end
      end
      ST_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = CNT_ZERO;
          tx_idx_d   = 3'd0;
          uart_tx_d  = tx_shift_q[0];
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = CNT_ZERO;
          if (tx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            uart_tx_d  = tx_par_q;
            tx_state_d = ST_PAR;
`else
            uart_tx_d  = 1'b1;
            tx_state_d = ST_STOP;
`endif
          end else begin
            // Shift register walks the byte LSB first; bit [1] is the next bit out.
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            uart_tx_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
`ifdef UART_PARITY_EN
      ST_PAR: begin
        if (tx_bit_end) begin
          tx_cnt_d   = CNT_ZERO;
          uart_tx_d  = 1'b1;
          tx_state_d = ST_STOP;
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d   = CNT_ZERO;
          busy_d     = 1'b0;
          tx_state_d = ST_IDLE;
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_cnt_d   = CNT_ZERO;
        uart_tx_d  = 1'b1;
        busy_d     = 1'b0;
        tx_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= CNT_ZERO;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      uart_tx_q  <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      uart_tx_q  <= uart_tx_d;
      busy_q     <= busy_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // ---------------- RX path ----------------
  state_e           rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_done_q, rx_done_d;
  logic [1:0]       rx_sync_q;
  logic             rx_prev_q;
  logic             rxs, rx_bit_end, rx_load, rx_clear;
  logic             parity_err_rd;
`ifdef UART_PARITY_EN
  logic             rx_par_bad_q, rx_par_bad_d;
  logic             parity_err_q, parity_err_d;
  logic             rx_par_set;
`endif

  assign rxs        = rx_sync_q[1];
  assign rx_bit_end = (rx_cnt_q == CNT_LAST);
  assign rx_clear   = (re & hit_rx) | (we & hit_done);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_load    = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_d = rx_par_bad_q;
    rx_par_set   = 1'b0;
`endif
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rxs) begin
          rx_cnt_d   = CNT_ZERO;
          rx_state_d = ST_START;
        end else begin
          rx_cnt_d   = CNT_ZERO;
        end
      end
      ST_START: begin
        // Re-check the start bit at its midpoint to reject short glitches.
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = CNT_ZERO;
          rx_idx_d   = 3'd0;
          rx_state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d   = rx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = CNT_ZERO;
          rx_shift_d = {rxs, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = ST_PAR;
`else
            rx_state_d = ST_STOP;
`endif
          end else begin
            rx_idx_d   = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
`ifdef UART_PARITY_EN
      ST_PAR: begin
        if (rx_bit_end) begin
          rx_cnt_d     = CNT_ZERO;
          rx_par_bad_d = (rxs != even_parity(rx_shift_q));
          rx_par_set   = (rxs != even_parity(rx_shift_q));
          rx_state_d   = ST_STOP;
        end else begin
          rx_cnt_d     = rx_cnt_q + CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = CNT_ZERO;
`ifdef UART_PARITY_EN
          rx_load    = rxs & ~rx_par_bad_q;
          rx_par_bad_d = 1'b0;
`else
          rx_load    = rxs;
`endif
          rx_state_d = ST_IDLE;
        end else begin
          rx_cnt_d   = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        rx_cnt_d   = CNT_ZERO;
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  // A completing byte takes priority over a same-cycle clear.
  always_comb begin
    rx_data_d = rx_load ? rx_shift_q : rx_data_q;
    if (rx_load) begin
      rx_done_d = 1'b1;
    end else if (rx_clear) begin
      rx_done_d = 1'b0;
    end else begin
      rx_done_d = rx_done_q;
    end
`ifdef UART_PARITY_EN
    if (rx_par_set) begin
      parity_err_d = 1'b1;
    end else if (we && hit_done) begin
      parity_err_d = 1'b0;
    end else begin
      parity_err_d = parity_err_q;
    end
    parity_err_rd = parity_err_q;
`else
    parity_err_rd = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= CNT_ZERO;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_done_q  <= 1'b0;
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
      rx_sync_q  <= {rx_sync_q[0], uart_rx};
      rx_prev_q  <= rxs;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= rx_par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Load data mux; TX_ADDR and unmatched addresses read as zero.
  always_comb begin
    if (re) begin
      case (addr)
        UART_RX_ADDR:      rdata = {24'h00_0000, rx_data_q};
        UART_BUSY_ADDR:    rdata = {31'h0000_0000, busy_q};
        UART_RX_DONE_ADDR: rdata = {30'h0000_0000, parity_err_rd, rx_done_q};
        default:           rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl with CLKS_PER_BIT=4: decode table plus TX/RX frame sequences.
module tb_uart_mmio_ctrl;

  localparam logic [31:0] A_TX   = 32'h1001_0300;
  localparam logic [31:0] A_RX   = 32'h1001_0304;
  localparam logic [31:0] A_BUSY = 32'h1001_0308;
  localparam logic [31:0] A_DONE = 32'h1001_030c;

  logic        clk = 1'b0;
  logic        rst, we, re, sel, uart_tx, uart_rx, rx_drv, loop_en;
  logic [31:0] addr, wdata, rdata;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic        exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  uart_mmio_ctrl #(.CLKS_PER_BIT(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .sel(sel), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a);
    we   = 1'b0;
    re   = 1'b1;
    addr = a;
    #1;
  endtask

  task automatic bus_store(input logic [31:0] a, input logic [31:0] d);
    we    = 1'b1;
    re    = 1'b0;
    addr  = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  // Drives one frame on rx_drv: start, 8 data bits LSB first, stop; 40 cycles total.
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    rx_drv = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (4) tick();
    end
    rx_drv = stop_b;
    repeat (4) tick();
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [9:0] frame_a5;
    int         waited;
    logic       saw_low;

    rst = 1'b1; we = 1'b0; re = 1'b0; addr = 32'h0; wdata = 32'h0;
    rx_drv = 1'b1; loop_en = 1'b0;
    frame_a5 = {1'b1, 8'hA5, 1'b0};

    vecs[0]  = '{A_DONE,        1'b1, 1'b1, 32'h0000_0001};
    vecs[1]  = '{A_BUSY,        1'b1, 1'b1, 32'h0000_0000};
    vecs[2]  = '{A_RX,          1'b0, 1'b1, 32'h0000_0000};
    vecs[3]  = '{A_TX,          1'b1, 1'b1, 32'h0000_0000};
    vecs[4]  = '{A_DONE,        1'b1, 1'b1, 32'h0000_0001};
    vecs[5]  = '{A_RX,          1'b1, 1'b1, 32'h0000_005A};
    vecs[6]  = '{A_DONE,        1'b1, 1'b1, 32'h0000_0000};
    vecs[7]  = '{A_RX,          1'b1, 1'b1, 32'h0000_005A};
    vecs[8]  = '{32'h1001_0310, 1'b1, 1'b0, 32'h0000_0000};
    vecs[9]  = '{32'h1001_0301, 1'b1, 1'b0, 32'h0000_0000};
    vecs[10] = '{32'h0001_0304, 1'b1, 1'b0, 32'h0000_0000};

    // Reset and idle
    repeat (2) tick();
    check("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("reset_rdata_re0", rdata, 32'h0);
    rst = 1'b0;
    tick();
    bus_read(A_BUSY);
    check("reset_busy", rdata, 32'h0);
    bus_read(A_DONE);
    check("reset_rx_done", rdata, 32'h0);
    tick();

    // TX frame 0xA5 with an ignored store while busy
    bus_store(A_TX, 32'h0000_00A5);
    for (int k = 0; k < 40; k++) begin
      if (k == 5) begin
        we = 1'b1; re = 1'b0; addr = A_TX; wdata = 32'h0000_003C;
        #1;
      end else begin
        bus_read(A_BUSY);
        check($sformatf("tx_busy_c%0d", k), rdata, 32'h1);
      end
      check($sformatf("tx_line_c%0d", k), {31'h0, uart_tx}, {31'h0, frame_a5[k/4]});
      tick();
    end
    bus_read(A_BUSY);
    check("tx_busy_after_frame", rdata, 32'h0);
    saw_low = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (uart_tx !== 1'b1) saw_low = 1'b1;
      tick();
    end
    check("tx_no_second_frame", {31'h0, saw_low}, 32'h0);

    // Loopback receive of 0x5A
    loop_en = 1'b1;
    bus_store(A_TX, 32'h0000_005A);
    bus_read(A_DONE);
    waited = 0;
    while (rdata[0] !== 1'b1 && waited < 120) begin
      tick();
      waited++;
    end
    check("loop_rx_done", rdata, 32'h1);
    check("loop_rx_latency", waited, 41);
    loop_en = 1'b0;

    // Decode / read-clear table
    for (int i = 0; i < 11; i++) begin
      we = 1'b0; re = vecs[i].re; addr = vecs[i].addr;
      #1;
      check($sformatf("tbl%0d_sel", i), {31'h0, sel}, {31'h0, vecs[i].exp_sel});
      check($sformatf("tbl%0d_rdata", i), rdata, vecs[i].exp_rdata);
      tick();
    end

    // Framing error: stop bit 0 discards the byte
    re = 1'b0;
    repeat (4) tick();
    send_frame(8'h33, 1'b0);
    repeat (10) tick();
    bus_read(A_DONE);
    check("frame_err_done", rdata, 32'h0);
    re = 1'b0;

    // One-cycle glitch on the line
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    repeat (50) tick();
    bus_read(A_DONE);
    check("glitch_done", rdata, 32'h0);
    bus_read(A_RX);
    check("glitch_rx_data", rdata, 32'h0000_005A);
    tick();

    // Set beats clear: RX load held through the completing edge of 0x11
    repeat (4) tick();
    bus_read(A_RX);
    send_frame(8'h11, 1'b1);
    tick();
    bus_read(A_DONE);
    check("set_wins_done", rdata, 32'h1);
    bus_read(A_RX);
    check("set_wins_data", rdata, 32'h0000_0011);
    re = 1'b0;
    tick();

    // Store to RX_DONE clears; store to RX/BUSY ignored
    bus_store(A_RX, 32'h0000_00FF);
    bus_store(A_BUSY, 32'h0000_0001);
    bus_read(A_RX);
    check("store_rx_ignored", rdata, 32'h0000_0011);
    bus_read(A_BUSY);
    check("store_busy_ignored", rdata, 32'h0);
    bus_store(A_DONE, 32'h0);
    bus_read(A_DONE);
    check("store_done_clears", rdata, 32'h0);
    re = 1'b0;

    // Mid-frame reset
    bus_store(A_TX, 32'h0000_0000);
    repeat (9) tick();
    check("midframe_line_low", {31'h0, uart_tx}, 32'h0);
    rst = 1'b1;
    tick();
    check("midframe_rst_tx", {31'h0, uart_tx}, 32'h1);
    bus_read(A_BUSY);
    check("midframe_rst_busy", rdata, 32'h0);
    bus_read(A_RX);
    check("midframe_rst_rx_data", rdata, 32'h0);
    rst = 1'b0;
    re = 1'b0;
    saw_low = 1'b0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (uart_tx !== 1'b1) saw_low = 1'b1;
    end
    check("midframe_no_resume", {31'h0, saw_low}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
